// File: rtl/rr_mux_arbiter.sv
// Round-robin N-channel mux with registered word, source index and one-hot grant.
// Latency: one cycle from input handshake to out_valid.
// Backpressure: a held beat blocks all in_ready until out_ready; drain and refill share an edge.
module rr_mux_arbiter #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_sel,
  output logic [N_CH-1:0]   out_grant
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] chosen;
  logic [N_CH-1:0]  elig;
  logic             any_elig;
  logic             load;
  logic [W-1:0]     chosen_data;

  assign load     = !out_valid || out_ready;
  assign any_elig = |elig;

  // Pick the eligible channel with the smallest upward distance from ptr.
  always_comb begin
    int best_d;
    int d;
    elig   = '0;
    chosen = '0;
    best_d = N_CH;
    d      = 0;
    for (int c = 0; c < N_CH; c++) begin
      elig[c] = in_valid[c] && (!mode || (int'(sel) == c));
      d = (c >= int'(ptr)) ? (c - int'(ptr)) : (c + N_CH - int'(ptr));
      if (elig[c] && (d < best_d)) begin
        best_d = d;
        chosen = SEL_W'(c);
      end
    end
  end

  // Ready is kept low during reset so no producer sees a phantom handshake.
  always_comb begin
    in_ready    = '0;
    chosen_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rst_n && load && any_elig && (chosen == SEL_W'(c)))
        in_ready[c] = 1'b1;
      if (chosen == SEL_W'(c))
        chosen_data = in_data[c*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_grant <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_grant <= in_ready;
      if (any_elig) begin
        out_valid <= 1'b1;
        out_data  <= chosen_data;
        out_sel   <= chosen;
        if (!mode)
          ptr <= (int'(chosen) == N_CH - 1) ? '0 : chosen + SEL_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a 4-channel and a 3-channel instance.
module tb_rr_mux_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid, in_ready, out_grant;
  logic           mode, out_valid, out_ready;
  logic [1:0]     sel, out_sel;
  logic [W-1:0]   out_data;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3, in_ready3, out_grant3;
  logic           mode3, out_valid3, out_ready3;
  logic [1:0]     sel3, out_sel3;
  logic [W-1:0]   out_data3;

  rr_mux_arbiter #(.N_CH(4), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_grant(out_grant)
  );

  rr_mux_arbiter #(.N_CH(3), .W(W)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_sel(out_sel3), .out_grant(out_grant3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s,
                         input logic [3:0] g, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
    chk({tag, ".grant"}, 32'(out_grant), 32'(g));
    chk({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  task automatic chk_out3(input string tag, input logic v, input logic [1:0] s,
                          input logic [2:0] g, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(out_valid3), 32'(v));
    chk({tag, ".sel"},   32'(out_sel3),   32'(s));
    chk({tag, ".grant"}, 32'(out_grant3), 32'(g));
    chk({tag, ".data"},  32'(out_data3),  32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rr_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] rr_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

  logic [2:0] r3_g [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
  logic [1:0] r3_s [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
  logic [7:0] r3_d [5] = '{8'h20, 8'h21, 8'h22, 8'h20, 8'h21};

  initial begin
    rst_n     = 1'b0;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid  = 4'b1111;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_data3  = {8'h22, 8'h21, 8'h20};
    in_valid3 = 3'b111;
    mode3     = 1'b0;
    sel3      = 2'd0;
    out_ready3 = 1'b1;

    // Reset held with inputs toggling: everything quiet.
    for (int i = 0; i < 3; i++) begin
      in_valid  = 4'(i * 5 + 3);
      in_valid3 = 3'(i * 3 + 5);
      tick();
      chk_out("rst", 1'b0, 2'd0, 4'b0000, 8'h00);
      chk("rst.rdy", 32'(in_ready), 32'd0);
      chk("rst.rdy3", 32'(in_ready3), 32'd0);
      chk("rst.valid3", 32'(out_valid3), 32'd0);
    end

    in_valid  = 4'b0000;
    in_valid3 = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle.valid", 32'(out_valid), 32'd0);
    chk("idle.rdy", 32'(in_ready), 32'd0);

    // Round-robin over four continuously valid channels.
    in_valid = 4'b1111;
    #1;
    chk("rr.rdy0", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1, rr_s[i], rr_g[i], rr_d[i]);
    end

    // Load channel 1 then 2, then stall with channel 2 held.
    tick();
    chk_out("pre1", 1'b1, 2'd1, 4'b0010, 8'h11);
    tick();
    chk_out("pre2", 1'b1, 2'd2, 4'b0100, 8'h12);
    out_ready = 1'b0;
    #1;
    chk("bp.rdy", 32'(in_ready), 32'd0);
    mode = 1'b1;
    sel  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("bp%0d", i), 1'b1, 2'd2, 4'b0100, 8'h12);
      chk($sformatf("bp%0d.rdy", i), 32'(in_ready), 32'd0);
    end
    mode = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp.rel.rdy", 32'(in_ready), 32'b1000);
    tick();
    chk_out("bp.rel", 1'b1, 2'd3, 4'b1000, 8'h13);

    // Forced select of channel 1; ptr sits at 0 throughout.
    mode = 1'b1;
    sel  = 2'd1;
    #1;
    chk("fs.rdy", 32'(in_ready), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("fs%0d", i), 1'b1, 2'd1, 4'b0010, 8'h11);
    end
    in_valid = 4'b1101;
    #1;
    chk("fs.empty.rdy", 32'(in_ready), 32'd0);
    tick();
    chk_out("fs.empty", 1'b0, 2'd1, 4'b0000, 8'h11);
    mode = 1'b0;
    in_valid = 4'b1111;
    #1;
    chk("fs.ptr.rdy", 32'(in_ready), 32'b0001);
    tick();
    chk_out("fs.ptr", 1'b1, 2'd0, 4'b0001, 8'h10);

    // Asynchronous reset while a beat is stalled.
    out_ready = 1'b0;
    tick();
    chk_out("mr.hold", 1'b1, 2'd0, 4'b0001, 8'h10);
    #1 rst_n = 1'b0;
    #1;
    chk_out("mr.async", 1'b0, 2'd0, 4'b0000, 8'h00);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mr.rdy", 32'(in_ready), 32'b0001);
    tick();
    chk_out("mr.first", 1'b1, 2'd0, 4'b0001, 8'h10);

    // Three channels: wrap 2 -> 0, then out-of-range forced select.
    in_valid3 = 3'b111;
    #1;
    chk("n3.rdy0", 32'(in_ready3), 32'b001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out3($sformatf("n3rr%0d", i), 1'b1, r3_s[i], r3_g[i], r3_d[i]);
    end
    mode3 = 1'b1;
    sel3  = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("n3oor%0d.rdy", i), 32'(in_ready3), 32'd0);
      tick();
      chk($sformatf("n3oor%0d.valid", i), 32'(out_valid3), 32'd0);
      chk($sformatf("n3oor%0d.grant", i), 32'(out_grant3), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Parametrised, registered N-channel multiplexer with a built-in round-robin arbiter and one-hot grant decoder. It is the sequential successor to the team's combinational 4-input mux and 2-to-4 decoder pair. It selects one of `N_CH` valid/ready input channels, registers the chosen word, and presents it with its channel index and one-hot grant on a single valid/ready output. It sits between multiple producers and one shared consumer. A forced-select mode keeps the plain-mux behaviour available.

## Interface
Parameters:
- `N_CH`, default 4: number of input channels; legal range 1 to 16; need not be a power of two.
- `W`, default 8: data width per channel.
- `SEL_W`, default `max(1, clog2(N_CH))`: derived width of the select and index fields. Do not override.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  N_CH*W: channel i occupies bits [i*W+W-1 : i*W].
- `in_valid`  in  N_CH: per-channel valid.
- `in_ready`  out  N_CH: per-channel ready; combinational; at most one bit set.
- `mode`  in  1: 0 = round-robin arbitration; 1 = forced select.
- `sel`  in  SEL_W: channel index used when `mode`=1.
- `out_data`  out  W: registered selected word.
- `out_valid`  out  1: registered; high while a beat is held.
- `out_ready`  in  1: consumer ready.
- `out_sel`  out  SEL_W: registered index of the held beat's source channel.
- `out_grant`  out  N_CH: registered one-hot decode of `out_sel`; all zero when `out_valid`=0.

## Operation
- Load enable is `load = !out_valid || out_ready`. The block has one output register stage and no skid buffer.
- Eligible set:
  - `mode`=0: all i with `in_valid[i]`.
  - `mode`=1: only i = `sel`, and only if `in_valid[sel]`. If `sel` >= `N_CH`, the set is empty.
- Round-robin choice: the first eligible index found searching upward from `ptr`, wrapping from N_CH-1 to 0.
- `ptr` is an internal register of SEL_W bits.
- `in_ready[c]` = `load` && (c is the chosen channel). Every other ready bit is 0.
- On a rising edge with `load` and a non-empty eligible set:
  - `out_data` <= `in_data[c]`; `out_sel` <= c; `out_grant` <= one-hot(c); `out_valid` <= 1.
  - In `mode`=0 only: `ptr` <= (c == N_CH-1) ? 0 : c+1.
  - In `mode`=1, `ptr` is unchanged.
- On a rising edge with `load` and an empty eligible set:
  - `out_valid` <= 0 and `out_grant` <= 0.
  - `out_data` and `out_sel` hold their previous values.
- With `out_valid`=1 and `out_ready`=0, all outputs hold, `ptr` holds, and `in_ready` is all 0.
- A change of `mode` or `sel` never alters the held beat. It affects only the next load.
- `N_CH`=1: `ptr` is constantly 0 and the block degenerates to a one-stage register slice.

## Timing
- Reset values, applied asynchronously on `rst_n` low: `out_valid`=0, `out_data`=0, `out_sel`=0, `out_grant`=0, `ptr`=0.
- Reset mid-operation discards any held beat with no handshake on either side.
- The first edge after `rst_n` rises uses `ptr`=0.
- Latency: an input handshake at edge k gives `out_valid`=1 after edge k. That is one cycle.
- Throughput: one beat per cycle when `out_ready` is held at 1.
- Simultaneous output drain and new load on the same edge is required. There must be no bubble.
- `in_ready` depends combinationally on `in_valid`, `mode`, `sel`, `out_valid`, `out_ready` and `ptr`. It must not depend on `in_data`.
- The fairness guarantee in `mode`=0: any continuously valid channel is granted within `N_CH` consecutive loads.

## Test plan
- Reset and idle: hold `rst_n`=0 with inputs toggling. Required: all outputs and `in_ready` are 0. After release with `in_valid`=0, `out_valid` stays 0.
- Round-robin fairness: `N_CH`=4, all `in_valid`=1111, `in_data` = 0x10,0x11,0x12,0x13, `out_ready`=1. Required grant order 0,1,2,3,0: `out_grant` = 0001,0010,0100,1000,0001 and `out_data` = 0x10..0x13, 0x10, one per cycle.
- Backpressure: beat from channel 2 held with `out_ready`=0 for 3 cycles. Required: `out_data`/`out_sel`/`out_grant` stable, `in_ready`=0000. On `out_ready`=1, the next grant is channel 3 on the same edge.
- Forced select: `mode`=1, `sel`=1, `in_valid`=1111. Required: only channel 1 is granted every cycle and `ptr` is unchanged. Then `sel`=1 with `in_valid[1]`=0: required `out_valid`=0 after the next edge.
- Non-power-of-two with out-of-range select: `N_CH`=3. In `mode`=0, grants are required to wrap 2 to 0. In `mode`=1 with `sel`=3, no `in_ready` bit ever rises.
- Reset mid-beat: `out_valid`=1 and `out_ready`=0, then pulse `rst_n` low between clock edges. Required: `out_valid` falls to 0 immediately without waiting for a clock edge, and the next grant starts at channel 0.
